// File: rtl/conv_window_sequencer.sv
// Walks every output position and filter of a conv layer through one shared kernel,
// streaming tagged results downstream. Optional build macro: CONV_SEQ_RELU_EN (fused ReLU on capture).
module conv_window_sequencer #(
    parameter int unsigned BITWIDTH     = 8,
    parameter int unsigned DATAHEIGHT   = 28,
    parameter int unsigned DATAWIDTH    = 28,
    parameter int unsigned FILTERHEIGHT = 5,
    parameter int unsigned FILTERWIDTH  = 5,
    parameter int unsigned FILTERBATCH  = 1,
    parameter int unsigned STRIDE       = 1,
    localparam int unsigned DW   = 2 * BITWIDTH,
    localparam int unsigned RW   = (DATAHEIGHT > 1) ? $clog2(DATAHEIGHT) : 1,
    localparam int unsigned CW   = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1,
    localparam int unsigned FW   = (FILTERBATCH > 1) ? $clog2(FILTERBATCH) : 1,
    localparam int unsigned OUTH = (DATAHEIGHT - FILTERHEIGHT) / STRIDE + 1,
    localparam int unsigned OUTW = (DATAWIDTH - FILTERWIDTH) / STRIDE + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 win_req,
    output logic [RW-1:0]        win_row,
    output logic [CW-1:0]        win_col,
    output logic [FW-1:0]        filter_idx,
    input  logic signed [DW-1:0] conv_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [RW-1:0]        out_row,
    output logic [CW-1:0]        out_col,
    output logic [FW-1:0]        out_filter
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, DONE} state_t;

    state_t              state;
    logic [RW-1:0]       orow, orow_nxt;
    logic [CW-1:0]       ocol, ocol_nxt;
    logic [FW-1:0]       filt, filt_nxt;
    logic                last_c;
    logic [DW-1:0]       capture_c;

    // Raster advance: filter fastest, then output column, then output row.
    always_comb begin
        orow_nxt = orow;
        ocol_nxt = ocol;
        filt_nxt = filt;
        if (filt == FW'(FILTERBATCH - 1)) begin
            filt_nxt = '0;
            if (ocol == CW'(OUTW - 1)) begin
                ocol_nxt = '0;
                orow_nxt = orow + RW'(1);
            end else begin
                ocol_nxt = ocol + CW'(1);
            end
        end else begin
            filt_nxt = filt + FW'(1);
        end
    end

    assign last_c = (orow == RW'(OUTH - 1)) && (ocol == CW'(OUTW - 1)) &&
                    (filt == FW'(FILTERBATCH - 1));

`ifdef CONV_SEQ_RELU_EN
    assign capture_c = conv_result[DW-1] ? '0 : conv_result;
`else
    assign capture_c = conv_result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            win_req    <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            filter_idx <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_filter <= '0;
            orow       <= '0;
            ocol       <= '0;
            filt       <= '0;
        end else begin
            win_req <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        win_req    <= 1'b1;
                        orow       <= '0;
                        ocol       <= '0;
                        filt       <= '0;
                        win_row    <= '0;
                        win_col    <= '0;
                        filter_idx <= '0;
                    end
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    out_data   <= capture_c;
                    out_row    <= orow;
                    out_col    <= ocol;
                    out_filter <= filt;
                    out_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_c) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            orow       <= orow_nxt;
                            ocol       <= ocol_nxt;
                            filt       <= filt_nxt;
                            win_row    <= RW'(32'(orow_nxt) * STRIDE);
                            win_col    <= CW'(32'(ocol_nxt) * STRIDE);
                            filter_idx <= filt_nxt;
                            win_req    <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Sequences a single shared combinational convolution kernel across an input feature map. It walks every output position and every filter, driving window coordinates and the filter index to the window and weight buffers. It then captures the kernel's signed result and delivers it downstream on a valid/ready stream tagged with its output coordinates. It sits between the layer controller (start/done) and the kernel datapath feeding the output feature-map writer.

## Interface
Parameters:
- BITWIDTH, 8, operand width; results are 2*BITWIDTH signed
- DATAHEIGHT, 28, input map rows
- DATAWIDTH, 28, input map columns
- FILTERHEIGHT, 5, kernel rows
- FILTERWIDTH, 5, kernel columns
- FILTERBATCH, 1, number of filters sharing the kernel
- STRIDE, 1, window step in both dimensions

Derived values:
- OUTH = (DATAHEIGHT-FILTERHEIGHT)/STRIDE+1 and OUTW likewise.
- RW = max(1,$clog2(DATAHEIGHT)) and CW = max(1,$clog2(DATAWIDTH)).
- FW = max(1,$clog2(FILTERBATCH)).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse after the final result handshake.
- win_req  out  1  one-cycle strobe: window/weight buffers load for the coordinates below.
- win_row  out  RW  top-left row of the current window.
- win_col  out  CW  top-left column of the current window.
- filter_idx  out  FW  filter (weight/bias set) select.
- conv_result  in  2*BITWIDTH  signed kernel output; valid in the cycle after win_req.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_data  out  2*BITWIDTH  captured signed result.
- out_row  out  RW  output-map row index (not pixel row).
- out_col  out  CW  output-map column index.
- out_filter  out  FW  filter index of out_data.

## Operation
- States: IDLE, FETCH, WAIT, OUT, DONE.
- IDLE: busy=0. If start=1, clear the counters (orow, ocol, filt) and go to FETCH.
- FETCH: win_req=1. Drive win_row=orow*STRIDE, win_col=ocol*STRIDE, filter_idx=filt. Go to WAIT.
- WAIT: hold win_row/win_col/filter_idx. At the end of the cycle, register conv_result into out_data. Register orow, ocol and filt into out_row, out_col and out_filter. Go to OUT.
- OUT: out_valid=1. out_data and the tags are stable until the handshake.
  - On out_valid&&out_ready, if this was the last result, go to DONE.
  - Otherwise advance the counters and go to FETCH.
- Iteration order: filt fastest, then ocol, then orow.
  - filt wraps at FILTERBATCH-1 and increments ocol.
  - ocol wraps at OUTW-1 and increments orow.
- Last result: orow=OUTH-1, ocol=OUTW-1, filt=FILTERBATCH-1.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- start outside IDLE is ignored, including start in the DONE cycle.
- Downstream stall: out_ready=0 holds OUT indefinitely, and no new fetch is issued.
- Arithmetic: no rounding or truncation; out_data equals conv_result bit-exact unless modified by the configuration feature.

## Timing
- Reset: state=IDLE. busy, done, win_req and out_valid are 0. win_row, win_col, filter_idx, out_data, out_row, out_col and out_filter are 0.
- rst mid-pass aborts immediately. The next cycle shows reset values, and no done is issued.
- start high at edge 0: FETCH in cycle 1 (win_req=1), WAIT in cycle 2, out_valid=1 in cycle 3.
- Throughput: 3 cycles per result with out_ready held high; each stall cycle adds 1.
- busy is 1 from cycle 1 through the DONE cycle inclusive.
- done is 1 in the cycle after the last handshake.

## Configuration
- CONV_SEQ_RELU_EN defined: the capture in WAIT clamps negative conv_result to 0 (ReLU fused); non-negative values pass unchanged.
- Undefined: conv_result is captured unmodified, including negatives.

## Test plan
- Raster order, 4x4 map, 3x3 filter, FILTERBATCH=2, STRIDE=1, out_ready=1:
  - start at cycle 0 produces 8 results at cycles 3,6,…,24.
  - Tags (r,c,f) run (0,0,0),(0,0,1),(0,1,0)…(1,1,1).
  - done pulses at cycle 25; busy is 0 at cycle 26.
- Stride: 5x5 map, 3x3 filter, STRIDE=2 gives win_col sequence 0,2,0,2 and win_row 0,0,2,2; out_col is 0,1,0,1.
- Backpressure: hold out_ready=0 for 5 cycles on the second result.
  - out_valid, out_data and the tags stay constant.
  - No win_req occurs while stalled.
  - The next win_req comes one cycle after the handshake.
- Sign and ReLU: the model returns conv_result=-300 (0xFED4, BITWIDTH=8).
  - Without CONV_SEQ_RELU_EN: out_data=0xFED4.
  - With it: out_data=0x0000.
  - +300 gives 0x012C in both builds.
- Reset and start edge cases:
  - rst asserted in the cycle of the third OUT returns all outputs to 0 next cycle, with no done.
  - A fresh start then restarts from (0,0,0).
  - start asserted while busy, and in the DONE cycle, is ignored.
